// File: rtl/riscv_pkg.sv
// Shared types and encodings for the RISC-V execute stage: control bundle,
// ALU operation codes, forwarding selects and the multiplier FSM states.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned MUL_CW = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alu_src;
    logic [2:0] funct3;
    logic [3:0] alu_control;
  } ctrl_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; codes without a single-cycle meaning
// (including MUL, which is produced by the sequential multiplier) yield 0.
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: ID/EX register, forwarding, ALU, branch resolution and EX/MEM register.
// Optional EX_SEQ_MUL_EN adds an iterative 32-cycle shift-add multiplier (code MUL).
module execute_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  ctrl_t             ctrl_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [1:0]        forward_a_e,
  input  logic [1:0]        forward_b_e,
  input  logic [XLEN-1:0]   result_w,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic              busy_e,
  output logic              valid_m,
  output ctrl_t             ctrl_m,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   write_data_m,
  output logic [XLEN-1:0]   pc_plus4_m,
  output logic [REG_AW-1:0] rd_m
);

  logic              valid_e;
  ctrl_t             ctrl_e;
  logic [XLEN-1:0]   rd1_e, rd2_e, pc_e, imm_e;
  logic [REG_AW-1:0] rd_e;
  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_out, ex_result;
  logic              taken;

  // ID/EX: flush inserts a bubble and wins over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
      pc_e    <= '0;
      imm_e   <= '0;
      rd_e    <= '0;
    end else if (flush_e) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
    end else if (!stall_e) begin
      valid_e <= valid_d;
      ctrl_e  <= ctrl_d;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
      pc_e    <= pc_d;
      imm_e   <= imm_d;
      rd_e    <= rd_d;
    end
  end

  always_comb begin
    case (forward_a_e)
      FWD_WB:  src_a = result_w;
      FWD_MEM: src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (forward_b_e)
      FWD_WB:  fwd_b = result_w;
      FWD_MEM: fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = ctrl_e.alu_src ? imm_e : fwd_b;

  alu u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (ctrl_e.alu_control),
    .result      (alu_out)
  );

  always_comb begin
    case (ctrl_e.funct3)
      3'b000:  taken = (src_a == fwd_b);
      3'b001:  taken = (src_a != fwd_b);
      3'b100:  taken = ($signed(src_a) <  $signed(fwd_b));
      3'b101:  taken = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  taken = (src_a <  fwd_b);
      3'b111:  taken = (src_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign pc_src_e    = valid_e & ((ctrl_e.branch & taken) | ctrl_e.jump);
  assign pc_target_e = ctrl_e.jalr ? (alu_out & ~XLEN'(1)) : (pc_e + imm_e);

`ifdef EX_SEQ_MUL_EN
  mul_state_t        state, state_next;
  logic [XLEN-1:0]   mul_acc, mul_mcand, mul_mplier;
  logic [MUL_CW-1:0] mul_count;
  logic              is_mul, mul_start, mul_step;

  assign is_mul = valid_e & (ctrl_e.alu_control == ALU_MUL);

  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MUL_IDLE: if (is_mul && !flush_e) state_next = MUL_BUSY;
      MUL_BUSY: begin
        if (flush_e)                               state_next = MUL_IDLE;
        else if (mul_count == MUL_CW'(XLEN - 1))   state_next = MUL_DONE;
      end
      MUL_DONE: if (flush_e || !stall_e) state_next = MUL_IDLE;
      default:  state_next = MUL_IDLE;
    endcase
  end

  always_comb begin
    busy_e    = 1'b0;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state)
      MUL_IDLE: begin
        busy_e    = is_mul;
        mul_start = is_mul & ~flush_e;
      end
      MUL_BUSY: begin
        busy_e   = 1'b1;
        mul_step = 1'b1;
      end
      default: ;
    endcase
  end

  // One multiplier bit per cycle, LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_count  <= '0;
    end else if (mul_start) begin
      mul_acc    <= '0;
      mul_mcand  <= src_a;
      mul_mplier <= src_b;
      mul_count  <= '0;
    end else if (mul_step) begin
      if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_count  <= mul_count + MUL_CW'(1);
    end
  end

  assign ex_result = (state == MUL_DONE) ? mul_acc : alu_out;
`else
  assign busy_e    = 1'b0;
  assign ex_result = alu_out;
`endif

  // EX/MEM captures every edge; only issued instructions are marked valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      ctrl_m       <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
      rd_m         <= '0;
    end else begin
      valid_m      <= valid_e & ~busy_e & ~stall_e & ~flush_e;
      ctrl_m       <= ctrl_e;
      alu_result_m <= ex_result;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_e + XLEN'(4);
      rd_m         <= rd_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic
// against a transaction-level reference model; MUL cases under EX_SEQ_MUL_EN.
module tb_execute_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_e, flush_e, valid_d;
  ctrl_t       ctrl_d;
  logic [31:0] rd1_d, rd2_d, pc_d, imm_d, result_w;
  logic [4:0]  rd_d;
  logic [1:0]  forward_a_e, forward_b_e;
  logic        pc_src_e, busy_e, valid_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  ctrl_t       ctrl_m;
  logic [4:0]  rd_m;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .pc_d(pc_d), .imm_d(imm_d), .rd_d(rd_d),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .busy_e(busy_e),
    .valid_m(valid_m), .ctrl_m(ctrl_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m), .rd_m(rd_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ctrl_t mk_ctrl(input logic [3:0] op, input logic asrc, input logic br,
                                    input logic jmp, input logic jr, input logic [2:0] f3);
    ctrl_t c;
    c = '0;
    c.reg_write   = 1'b1;
    c.alu_control = op;
    c.alu_src     = asrc;
    c.branch      = br;
    c.jump        = jmp;
    c.jalr        = jr;
    c.funct3      = f3;
    return c;
  endfunction

  // Present one instruction on the D inputs and clock it into EX
  task automatic issue(input ctrl_t c, input logic v, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] imm);
    valid_d = v; ctrl_d = c; rd1_d = r1; rd2_d = r2; pc_d = pc; imm_d = imm; rd_d = 5'd9;
    tick();
    valid_d = 1'b0; ctrl_d = '0;
  endtask

  // Reference ALU from the opcode table, plain arithmetic
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh  = int'(b[4:0]);
    ext = {{32{a[31]}}, a} >> sh;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return ext[31:0];
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_v,
                                       input logic [31:0] wb_v, input logic [31:0] mem_v);
    if (sel == 2'd1) return wb_v;
    if (sel == 2'd2) return mem_v;
    return reg_v;
  endfunction

`ifdef EX_SEQ_MUL_EN
  task automatic mul_run(input logic [31:0] x, input logic [31:0] y, input logic [31:0] prod);
    int busy_cnt;
    issue(mk_ctrl(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, x, y, 32'h0, 32'h0);
    stall_e  = 1'b1;
    busy_cnt = 0;
    while (busy_e === 1'b1 && busy_cnt < 100) begin
      check("mul_valid_m_busy", 32'(valid_m), 32'd0);
      busy_cnt++;
      tick();
    end
    stall_e = 1'b0;
    check("mul_busy_cycles", 32'(busy_cnt), 32'd33);
    tick();
    check("mul_valid_m", 32'(valid_m), 32'd1);
    check("mul_product", alu_result_m, prod);
  endtask

  task automatic mul_abort(input logic use_rst);
    issue(mk_ctrl(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'd7, 32'd6, 32'h0, 32'h0);
    stall_e = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    if (use_rst) rst = 1'b1; else flush_e = 1'b1;
    tick();
    rst = 1'b0; flush_e = 1'b0; stall_e = 1'b0;
    check("abort_busy", 32'(busy_e), 32'd0);
    check("abort_valid_m", 32'(valid_m), 32'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("abort_no_result", 32'(valid_m), 32'd0);
    end
  endtask
`endif

  // Model ID/EX contents and the previous EX result
  logic        m_valid;
  ctrl_t       m_ctrl;
  logic [31:0] m_rd1, m_rd2, m_pc, m_imm, m_alu_m;
  logic [4:0]  m_rd;
  logic [31:0] a, fb, b, res;
  logic [14:0] rbits;
  logic [3:0]  op;
  logic        exp_vm;

  initial begin
    rst = 1'b1; stall_e = 1'b0; flush_e = 1'b0; valid_d = 1'b0; ctrl_d = '0;
    rd1_d = '0; rd2_d = '0; pc_d = '0; imm_d = '0; rd_d = '0;
    forward_a_e = 2'b00; forward_b_e = 2'b00; result_w = '0;
    tick(); tick();
    check("rst_valid_m", 32'(valid_m), 32'd0);
    check("rst_alu_result_m", alu_result_m, 32'd0);
    check("rst_pc_plus4_m", pc_plus4_m, 32'd0);
    check("rst_ctrl_m", 32'(ctrl_m), 32'd0);
    check("rst_busy", 32'(busy_e), 32'd0);
    check("rst_pc_src", 32'(pc_src_e), 32'd0);
    rst = 1'b0;

    // Forward from MEM: 7 then 7 + 3
    issue(mk_ctrl(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'd4, 32'd0, 32'h40, 32'd3);
    issue(mk_ctrl(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'd5, 32'd0, 32'h44, 32'd3);
    check("fwd_prev_result", alu_result_m, 32'd7);
    check("fwd_prev_valid", 32'(valid_m), 32'd1);
    check("fwd_prev_pc4", pc_plus4_m, 32'h44);
    forward_a_e = 2'b10;
    tick();
    forward_a_e = 2'b00;
    check("fwd_mem_add", alu_result_m, 32'd10);

    issue(mk_ctrl(4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'h80000000, 32'd0, 32'h0, 32'd4);
    tick(); check("sra", alu_result_m, 32'hF8000000);
    issue(mk_ctrl(4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'h80000000, 32'd0, 32'h0, 32'd4);
    tick(); check("srl", alu_result_m, 32'h08000000);
    issue(mk_ctrl(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'h80000000, 32'd0, 32'h0, 32'd1);
    tick(); check("sltu", alu_result_m, 32'd0);
    issue(mk_ctrl(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'h80000000, 32'd0, 32'h0, 32'd1);
    tick(); check("slt", alu_result_m, 32'd1);
    issue(mk_ctrl(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b0, 32'd3, 32'd0, 32'h0, 32'd5);
    tick(); check("undef_op_bubble_valid", 32'(valid_m), 32'd0);

    // Branches
    issue(mk_ctrl(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100), 1'b1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20);
    check("blt_taken", 32'(pc_src_e), 32'd1);
    check("blt_target", pc_target_e, 32'h120);
    issue(mk_ctrl(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110), 1'b1, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20);
    check("bltu_not_taken", 32'(pc_src_e), 32'd0);
    issue(mk_ctrl(4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100), 1'b0, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h20);
    check("blt_invalid", 32'(pc_src_e), 32'd0);
    issue(mk_ctrl(4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000), 1'b1, 32'h1001, 32'd0, 32'h200, 32'h10);
    check("jalr_taken", 32'(pc_src_e), 32'd1);
    check("jalr_target", pc_target_e, 32'h1010);

    // Stall holds, then issues
    issue(mk_ctrl(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0), 1'b1, 32'd1, 32'd0, 32'h0, 32'd1);
    stall_e = 1'b1;
    tick();
    stall_e = 1'b0;
    check("stall_valid_m", 32'(valid_m), 32'd0);
    tick();
    check("stall_release_valid", 32'(valid_m), 32'd1);
    check("stall_release_result", alu_result_m, 32'd2);

    // Stall and flush together: flush wins
    issue(mk_ctrl(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0), 1'b1, 32'd0, 32'd0, 32'h300, 32'h8);
    check("jal_taken", 32'(pc_src_e), 32'd1);
    stall_e = 1'b1; flush_e = 1'b1;
    tick();
    stall_e = 1'b0; flush_e = 1'b0;
    check("stall_flush_valid_m", 32'(valid_m), 32'd0);
    check("stall_flush_pc_src", 32'(pc_src_e), 32'd0);
    tick();
    check("stall_flush_valid_m2", 32'(valid_m), 32'd0);

`ifdef EX_SEQ_MUL_EN
    mul_run(32'd7, 32'd6, 32'd42);
    mul_run(32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
    mul_abort(1'b0);
    mul_abort(1'b1);
`endif

    // Randomized traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_imm = '0; m_rd = '0;
    m_alu_m = '0;
    for (int it = 0; it < 400; it++) begin
      rbits = 15'($urandom);
      op    = 4'($urandom_range(0, 15));
`ifdef EX_SEQ_MUL_EN
      if (op == 4'd10) op = 4'd11;
`endif
      ctrl_d = rbits;
      ctrl_d.alu_control = op;
      valid_d = 1'($urandom);
      rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; imm_d = $urandom;
      rd_d = 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin rd2_d = rd1_d; imm_d = 32'($urandom_range(0, 40)); end
      stall_e = ($urandom_range(0, 3) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      forward_a_e = 2'($urandom); forward_b_e = 2'($urandom);
      result_w = $urandom;
      #1;
      a   = pick(forward_a_e, m_rd1, result_w, m_alu_m);
      fb  = pick(forward_b_e, m_rd2, result_w, m_alu_m);
      b   = m_ctrl.alu_src ? m_imm : fb;
      res = ref_alu(m_ctrl.alu_control, a, b);
      check("rnd_pc_src", 32'(pc_src_e),
            32'(m_valid && ((m_ctrl.branch && ref_taken(m_ctrl.funct3, a, fb)) || m_ctrl.jump)));
      check("rnd_pc_target", pc_target_e, m_ctrl.jalr ? {res[31:1], 1'b0} : m_pc + m_imm);
      exp_vm = m_valid && !stall_e && !flush_e;
      tick();
      check("rnd_valid_m", 32'(valid_m), 32'(exp_vm));
      check("rnd_alu_result_m", alu_result_m, res);
      check("rnd_write_data_m", write_data_m, fb);
      check("rnd_pc_plus4_m", pc_plus4_m, m_pc + 32'd4);
      check("rnd_rd_m", 32'(rd_m), 32'(m_rd));
      check("rnd_ctrl_m", 32'(ctrl_m), 32'(m_ctrl));
      m_alu_m = res;
      if (flush_e) begin
        m_valid = 1'b0; m_ctrl = '0;
      end else if (!stall_e) begin
        m_valid = valid_d; m_ctrl = ctrl_d; m_rd1 = rd1_d; m_rd2 = rd2_d;
        m_pc = pc_d; m_imm = imm_d; m_rd = rd_d;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
